// File: rtl/hazard_ctrl_if.sv
// hazard_ctrl_if: hazard inputs and sequencing outputs
// exchanged between the pipeline and the hazard controller.
interface hazard_ctrl_if #(
    parameter int CNT_W = 16
);
    logic [3:0]       if_id_rs;
    logic [3:0]       if_id_rt;
    logic             if_id_uses_rs;
    logic             if_id_uses_rt;
    logic [3:0]       id_ex_rd;
    logic             id_ex_memread;
    logic             ex_mem_memread;
    logic             ex_mem_memwrite;
    logic             dmem_rdy;
    logic             branch_taken;
    logic             halt_in;
    logic             pc_write;
    logic             if_id_write;
    logic             id_ex_write;
    logic             ex_mem_write;
    logic             if_id_flush;
    logic             id_ex_bubble;
    logic             mem_wb_bubble;
    logic             mem_err;
    logic [CNT_W-1:0] stall_cycles;

    modport master (
        output if_id_rs, if_id_rt,
        output if_id_uses_rs, if_id_uses_rt,
        output id_ex_rd, id_ex_memread,
        output ex_mem_memread, ex_mem_memwrite,
        output dmem_rdy, branch_taken, halt_in,
        input  pc_write, if_id_write,
        input  id_ex_write, ex_mem_write,
        input  if_id_flush, id_ex_bubble,
        input  mem_wb_bubble, mem_err, stall_cycles
    );

    modport slave (
        input  if_id_rs, if_id_rt,
        input  if_id_uses_rs, if_id_uses_rt,
        input  id_ex_rd, id_ex_memread,
        input  ex_mem_memread, ex_mem_memwrite,
        input  dmem_rdy, branch_taken, halt_in,
        output pc_write, if_id_write,
        output id_ex_write, ex_mem_write,
        output if_id_flush, id_ex_bubble,
        output mem_wb_bubble, mem_err, stall_cycles
    );
endinterface

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: pipeline sequencing for load-use stalls,
// branch flushes, data-memory waits with watchdog, and halt.
module hazard_ctrl #(
    parameter int MEM_TIMEOUT = 15,
    parameter int CNT_W       = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    hazard_ctrl_if.slave hz
);
    typedef enum logic [1:0] {
        S_RUN,
        S_MEMWAIT,
        S_HALTED
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [7:0]       r_wait_cnt;
    logic [7:0]       w_wait_nxt;
    logic             r_mem_err;
    logic             w_err_nxt;
    logic [CNT_W-1:0] r_stall;

    logic w_mem_busy;
    logic w_load_use;
    logic w_rs_hit;
    logic w_rt_hit;
    logic w_pc_write;
    logic w_if_id_write;
    logic w_id_ex_write;
    logic w_ex_mem_write;
    logic w_if_id_flush;
    logic w_id_ex_bubble;
    logic w_mem_wb_bubble;

    localparam logic [7:0] TO = 8'(MEM_TIMEOUT);

    assign w_mem_busy = (hz.ex_mem_memread | hz.ex_mem_memwrite)
                      & ~hz.dmem_rdy;
    assign w_rs_hit   = hz.if_id_uses_rs
                      & (hz.if_id_rs == hz.id_ex_rd);
    assign w_rt_hit   = hz.if_id_uses_rt
                      & (hz.if_id_rt == hz.id_ex_rd);
    assign w_load_use = hz.id_ex_memread
                      & (hz.id_ex_rd != 4'd0)
                      & (w_rs_hit | w_rt_hit);

    // Zero-latency hazard outputs; all off in reset or once halted.
    always_comb begin
        w_pc_write      = 1'b0;
        w_if_id_write   = 1'b0;
        w_id_ex_write   = 1'b0;
        w_ex_mem_write  = 1'b0;
        w_if_id_flush   = 1'b0;
        w_id_ex_bubble  = 1'b0;
        w_mem_wb_bubble = 1'b0;
        if (rst_n && (r_state != S_HALTED)) begin
            if (w_mem_busy) begin
                w_mem_wb_bubble = 1'b1;
            end else if (hz.halt_in) begin
                w_pc_write = 1'b0;
            end else if (hz.branch_taken) begin
                w_pc_write     = 1'b1;
                w_if_id_write  = 1'b1;
                w_id_ex_write  = 1'b1;
                w_ex_mem_write = 1'b1;
                w_if_id_flush  = 1'b1;
                w_id_ex_bubble = 1'b1;
            end else if (w_load_use) begin
                w_id_ex_write  = 1'b1;
                w_ex_mem_write = 1'b1;
                w_id_ex_bubble = 1'b1;
            end else begin
                w_pc_write     = 1'b1;
                w_if_id_write  = 1'b1;
                w_id_ex_write  = 1'b1;
                w_ex_mem_write = 1'b1;
            end
        end
    end

    // Next state, wait counter and watchdog error.
    always_comb begin
        w_state_nxt = r_state;
        w_wait_nxt  = r_wait_cnt;
        w_err_nxt   = r_mem_err;
        unique case (r_state)
            S_RUN: begin
                if (w_mem_busy) begin
                    w_state_nxt = S_MEMWAIT;
                    w_wait_nxt  = 8'd1;
                end else if (hz.halt_in) begin
                    w_state_nxt = S_HALTED;
                end
            end
            S_MEMWAIT: begin
                if (w_mem_busy) begin
                    if (r_wait_cnt >= TO) begin
                        w_state_nxt = S_HALTED;
                        w_err_nxt   = 1'b1;
                    end else begin
                        w_wait_nxt = r_wait_cnt + 8'd1;
                    end
                end else begin
                    w_state_nxt = S_RUN;
                    w_wait_nxt  = 8'd0;
                end
            end
            S_HALTED: begin
                w_state_nxt = S_HALTED;
            end
            default: begin
                w_state_nxt = S_RUN;
                w_wait_nxt  = 8'd0;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_RUN;
            r_wait_cnt <= 8'd0;
            r_mem_err  <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_wait_cnt <= w_wait_nxt;
            r_mem_err  <= w_err_nxt;
        end
    end

    // Saturating count of stalled cycles while not halted.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stall <= '0;
        end else if ((r_state != S_HALTED) && !w_pc_write
                     && (r_stall != {CNT_W{1'b1}})) begin
            r_stall <= r_stall + 1'b1;
        end
    end

    assign hz.pc_write      = w_pc_write;
    assign hz.if_id_write   = w_if_id_write;
    assign hz.id_ex_write   = w_id_ex_write;
    assign hz.ex_mem_write  = w_ex_mem_write;
    assign hz.if_id_flush   = w_if_id_flush;
    assign hz.id_ex_bubble  = w_id_ex_bubble;
    assign hz.mem_wb_bubble = w_mem_wb_bubble;
    assign hz.mem_err       = r_mem_err;
    assign hz.stall_cycles  = r_stall;
endmodule

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl: scoreboard bench with a behavioural model
// of the hazard controller driven by directed and random stimulus.
module tb_hazard_ctrl;
    localparam int TO = 15;
    localparam int CW = 5;
    localparam int SMAX = (1 << CW) - 1;

    typedef struct packed {
        logic       rst_n;
        logic [3:0] rs;
        logic [3:0] rt;
        logic       urs;
        logic       urt;
        logic [3:0] rd;
        logic       ld;
        logic       mrd;
        logic       mwr;
        logic       rdy;
        logic       br;
        logic       hlt;
    } in_t;

    typedef struct packed {
        logic          pc;
        logic          ifid;
        logic          idex;
        logic          exmem;
        logic          flush;
        logic          bub;
        logic          mwb;
        logic          err;
        logic [CW-1:0] stall;
    } out_t;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    hazard_ctrl_if #(.CNT_W(CW)) hz ();

    hazard_ctrl #(.MEM_TIMEOUT(TO), .CNT_W(CW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .hz    (hz.slave)
    );

    out_t exp_q[$];
    int   cyc_q[$];
    int   checks = 0;
    int   failures = 0;
    int   cyc = 0;

    bit m_halted;
    bit m_err;
    int m_frozen_run;
    int m_stall;

    function automatic in_t idle();
        in_t s;
        s = '0;
        s.rst_n = 1'b1;
        s.rdy = 1'b1;
        return s;
    endfunction

    function automatic out_t model_out(in_t s);
        out_t o;
        bit   frozen;
        bit   lu;
        o = '0;
        if (!s.rst_n) return o;
        o.err = m_err;
        o.stall = CW'(m_stall);
        if (m_halted) return o;
        frozen = (s.mrd || s.mwr) && !s.rdy;
        lu = s.ld && (s.rd != 0) &&
             ((s.urs && s.rs == s.rd) || (s.urt && s.rt == s.rd));
        if (frozen) begin
            o.mwb = 1'b1;
        end else if (s.hlt) begin
            o.pc = 1'b0;
        end else if (s.br) begin
            {o.pc, o.ifid, o.idex, o.exmem} = 4'hf;
            o.flush = 1'b1;
            o.bub = 1'b1;
        end else if (lu) begin
            o.idex = 1'b1;
            o.exmem = 1'b1;
            o.bub = 1'b1;
        end else begin
            {o.pc, o.ifid, o.idex, o.exmem} = 4'hf;
        end
        return o;
    endfunction

    task automatic model_edge(in_t s, out_t o);
        bit frozen;
        if (!s.rst_n) begin
            m_halted = 0;
            m_err = 0;
            m_frozen_run = 0;
            m_stall = 0;
            return;
        end
        if (m_halted) return;
        if (!o.pc && m_stall < SMAX) m_stall++;
        frozen = (s.mrd || s.mwr) && !s.rdy;
        if (frozen) begin
            m_frozen_run++;
            if (m_frozen_run > TO) begin
                m_halted = 1;
                m_err = 1;
            end
        end else begin
            if (s.hlt && m_frozen_run == 0) m_halted = 1;
            m_frozen_run = 0;
        end
    endtask

    task automatic drive(in_t s);
        out_t o;
        @(negedge clk);
        rst_n              = s.rst_n;
        hz.if_id_rs        = s.rs;
        hz.if_id_rt        = s.rt;
        hz.if_id_uses_rs   = s.urs;
        hz.if_id_uses_rt   = s.urt;
        hz.id_ex_rd        = s.rd;
        hz.id_ex_memread   = s.ld;
        hz.ex_mem_memread  = s.mrd;
        hz.ex_mem_memwrite = s.mwr;
        hz.dmem_rdy        = s.rdy;
        hz.branch_taken    = s.br;
        hz.halt_in         = s.hlt;
        o = model_out(s);
        exp_q.push_back(o);
        cyc_q.push_back(cyc);
        cyc++;
        model_edge(s, o);
    endtask

    // Monitor: compare DUT outputs against queued expectations.
    initial begin
        out_t a;
        out_t e;
        int   c;
        forever begin
            @(negedge clk);
            #1;
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                c = cyc_q.pop_front();
                a.pc    = hz.pc_write;
                a.ifid  = hz.if_id_write;
                a.idex  = hz.id_ex_write;
                a.exmem = hz.ex_mem_write;
                a.flush = hz.if_id_flush;
                a.bub   = hz.id_ex_bubble;
                a.mwb   = hz.mem_wb_bubble;
                a.err   = hz.mem_err;
                a.stall = hz.stall_cycles;
                checks++;
                if (a !== e) begin
                    failures++;
                    $display("FAIL cyc%0d outputs got pc,ifid,idex,exmem,flush,bub,mwb,err=%b stall=%0d exp %b stall=%0d",
                             c, a[CW+7:CW], a.stall, e[CW+7:CW], e.stall);
                end
            end
        end
    end

    initial begin
        in_t s;
        int  burst;
        rst_n = 1'b0;
        hz.if_id_rs = '0;
        hz.if_id_rt = '0;
        hz.if_id_uses_rs = 1'b0;
        hz.if_id_uses_rt = 1'b0;
        hz.id_ex_rd = '0;
        hz.id_ex_memread = 1'b0;
        hz.ex_mem_memread = 1'b0;
        hz.ex_mem_memwrite = 1'b0;
        hz.dmem_rdy = 1'b1;
        hz.branch_taken = 1'b0;
        hz.halt_in = 1'b0;
        m_halted = 0;
        m_err = 0;
        m_frozen_run = 0;
        m_stall = 0;

        s = idle();
        s.rst_n = 1'b0;
        drive(s);
        drive(s);
        drive(idle());

        s = idle();
        s.ld = 1; s.rd = 5; s.rs = 5; s.urs = 1;
        drive(s);
        drive(idle());

        s = idle();
        s.ld = 1; s.rd = 0; s.rs = 0; s.urs = 1;
        drive(s);
        s = idle();
        s.ld = 1; s.rd = 7; s.rt = 7; s.urt = 0;
        drive(s);

        s = idle();
        s.ld = 1; s.rd = 3; s.rs = 3; s.urs = 1; s.br = 1;
        drive(s);
        drive(idle());

        s = idle();
        s.mrd = 1; s.rdy = 0;
        repeat (3) drive(s);
        s.rdy = 1;
        drive(s);
        drive(idle());

        s = idle();
        s.mwr = 1; s.rdy = 0;
        repeat (15) drive(s);
        s.rdy = 1;
        drive(s);
        drive(idle());

        s = idle();
        s.mrd = 1; s.rdy = 0;
        repeat (18) drive(s);
        s = idle();
        s.br = 1;
        drive(s);
        s = idle();
        s.rst_n = 0;
        drive(s);
        drive(idle());

        s = idle();
        s.hlt = 1; s.br = 1;
        drive(s);
        s = idle();
        s.br = 1;
        drive(s);
        s = idle();
        s.ld = 1; s.rd = 2; s.rs = 2; s.urs = 1;
        drive(s);
        s = idle();
        s.rst_n = 0;
        drive(s);

        burst = 0;
        for (int i = 0; i < 1200; i++) begin
            s = idle();
            s.rst_n = ($urandom_range(0, 149) != 0);
            s.rs  = 4'($urandom_range(0, 3));
            s.rt  = 4'($urandom_range(0, 3));
            s.rd  = 4'($urandom_range(0, 3));
            s.urs = 1'($urandom);
            s.urt = 1'($urandom);
            s.ld  = 1'($urandom);
            s.br  = ($urandom_range(0, 5) == 0);
            s.hlt = ($urandom_range(0, 59) == 0);
            s.mrd = ($urandom_range(0, 3) == 0);
            s.mwr = ($urandom_range(0, 5) == 0);
            s.rdy = ($urandom_range(0, 2) != 0);
            if (burst == 0 && $urandom_range(0, 49) == 0)
                burst = $urandom_range(12, 20);
            if (burst > 0) begin
                s.mrd = 1;
                s.rdy = 0;
                s.hlt = 0;
                burst--;
            end
            drive(s);
        end

        drive(idle());
        repeat (3) @(negedge clk);
        #2;
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL drain pending=%0d required=0",
                     exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d",
                 checks, failures);
        $finish;
    end
endmodule

// File: doc/hazard_ctrl.md
# hazard_ctrl

Pipeline sequencing controller for the 5-stage, 16-register core. It generates every pipeline-register write enable, bubble and flush. It covers load-use stalls, taken-branch flushes, multi-cycle data-memory waits with a watchdog, and the terminal halt. It sits beside the forwarding unit: forwarding covers EX/MEM and MEM/WB producers, and this block handles every hazard forwarding cannot resolve.

## Interface
- MEM_TIMEOUT, 15: max consecutive frozen cycles waiting on dmem_rdy before error halt (1..255)
- CNT_W, 16: width of stall_cycles
- clk  in  1  core clock, all state on rising edge
- rst_n  in  1  asynchronous, active-low reset
- if_id_rs, if_id_rt  in  4  source registers of instruction in ID
- if_id_uses_rs, if_id_uses_rt  in  1  ID instruction actually reads rs / rt
- id_ex_rd  in  4  destination of instruction in EX
- id_ex_memread  in  1  EX instruction is a load
- ex_mem_memread, ex_mem_memwrite  in  1  MEM-stage instruction accesses data memory
- dmem_rdy  in  1  data memory completes access this cycle
- branch_taken  in  1  branch resolved taken in EX this cycle
- halt_in  in  1  halt instruction is in MEM/WB
- pc_write, if_id_write, id_ex_write, ex_mem_write  out  1  register write enables
- if_id_flush  out  1  load NOP into IF/ID
- id_ex_bubble  out  1  load NOP into ID/EX
- mem_wb_bubble  out  1  load NOP into MEM/WB
- mem_err  out  1  sticky watchdog error
- stall_cycles  out  CNT_W  saturating count of cycles with pc_write=0 outside HALTED

## Operation
- States: RUN, MEMWAIT, HALTED.
- Derived signals:
  - mem_busy = (ex_mem_memread | ex_mem_memwrite) & ~dmem_rdy.
  - load_use = id_ex_memread & (id_ex_rd != 0) & ((if_id_uses_rs & if_id_rs == id_ex_rd) | (if_id_uses_rt & if_id_rt == id_ex_rd)). R0 never causes a stall.
- Outputs are combinational from state and inputs. Priority in RUN/MEMWAIT, highest first:
  1. Freeze, when mem_busy: all four write enables 0, mem_wb_bubble=1, flush/id_ex_bubble 0.
  2. Halt, when halt_in: all write enables 0, all bubbles/flush 0.
  3. Branch, when branch_taken: pc_write=1, if_id_flush=1, id_ex_bubble=1, other enables 1. Branch overrides a simultaneous load_use because the dependent instruction is flushed.
  4. Load-use, when load_use: pc_write=0, if_id_write=0, id_ex_bubble=1, id_ex_write=1, ex_mem_write=1. Exactly one bubble is inserted; forwarding covers the rest.
  5. Otherwise: all write enables 1, bubbles/flush 0.
- Transitions:
  - RUN to MEMWAIT on mem_busy, with wait_cnt set to 1.
  - RUN to HALTED on halt_in & ~mem_busy.
  - MEMWAIT to RUN when dmem_rdy=1; outputs follow priorities 2-5 that cycle, so the pipeline advances.
  - MEMWAIT stays while mem_busy & wait_cnt < MEM_TIMEOUT, incrementing wait_cnt each cycle.
  - MEMWAIT to HALTED when mem_busy & wait_cnt == MEM_TIMEOUT; mem_err is set at that edge.
  - HALTED is terminal until reset. All write enables, bubbles and flush are 0, and inputs are ignored.
- stall_cycles increments on each edge where pc_write=0 and state is not HALTED. It saturates at all-ones.

## Timing
- While rst_n=0: state=RUN, wait_cnt=0, mem_err=0, stall_cycles=0, all write enables/bubbles/flush forced 0. Reset assertion is asynchronous and immediate.
- First rising edge after rst_n deasserts: normal RUN behaviour.
- Latency:
  - Hazard outputs are zero-cycle (same cycle as the causing inputs).
  - State, wait_cnt, mem_err and stall_cycles update on the next edge.
- A memory wait of N cycles (dmem_rdy low N cycles, high on cycle N+1) gives N frozen cycles. wait_cnt peaks at N, and the watchdog fires iff N > MEM_TIMEOUT.
- Reset mid-MEMWAIT or in HALTED returns to RUN with mem_err cleared.
- dmem_rdy is ignored when no memory access is in MEM.

## Test plan
- Load-use: id_ex_memread=1, id_ex_rd=5, if_id_rs=5, uses_rs=1 for one cycle -> pc_write=0, if_id_write=0, id_ex_bubble=1 that cycle; stall_cycles 0->1.
- R0 / unused operand: id_ex_rd=0 with rs=0, or rt match with uses_rt=0 -> no stall, all enables 1.
- Branch plus load-use in the same cycle -> pc_write=1, if_id_flush=1, id_ex_bubble=1; stall_cycles unchanged.
- Memory wait: ex_mem_memread=1, dmem_rdy low 3 cycles then high -> 3 frozen cycles with mem_wb_bubble=1, release on 4th; state back to RUN; stall_cycles +3.
- Watchdog: MEM_TIMEOUT=15, dmem_rdy held low -> HALTED and mem_err=1 after the 16th frozen edge; all enables 0 thereafter; rst_n pulse clears it.
- Halt: halt_in=1 with branch_taken=1 -> all enables 0 that cycle, HALTED next; further branch/load-use inputs have no effect; stall_cycles frozen.
